// File: rtl/nrisc_return_stack_pkg.sv
// Shared stack command encodings and default widths for the NRISC return stack.
// The CPU decoder imports the same encodings.
package nrisc_return_stack_pkg;

  localparam int STACK_DATA_W = 16;
  localparam int STACK_FLAG_W = 3;
  localparam int STACK_DEPTH  = 8;
  localparam int STACK_PTR_W  = 3;

  typedef enum logic [1:0] {
    STACK_OP_IDLE = 2'b00,
    STACK_OP_PUSH = 2'b01,
    STACK_OP_POP  = 2'b10,
    STACK_OP_REPL = 2'b11
  } stack_op_e;

endpackage

// File: rtl/nrisc_return_stack_if.sv
// Command/status bundle between the CPU control FSM (master) and the return stack (slave).
interface nrisc_return_stack_if
  import nrisc_return_stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int FLAG_W = STACK_FLAG_W,
  parameter int PTR_W  = STACK_PTR_W
);

  logic              STACK_valid;
  logic [1:0]        STACK_ctrl;
  logic [DATA_W-1:0] STACK_push_addr;
  logic [FLAG_W-1:0] STACK_push_flags;
  logic              STACK_err_clr;
  logic [DATA_W-1:0] STACK_top_addr;
  logic [FLAG_W-1:0] STACK_top_flags;
  logic [PTR_W:0]    STACK_count;
  logic              STACK_empty;
  logic              STACK_full;
  logic              STACK_overflow;
  logic              STACK_underflow;

  modport master (
    output STACK_valid, STACK_ctrl, STACK_push_addr, STACK_push_flags, STACK_err_clr,
    input  STACK_top_addr, STACK_top_flags, STACK_count, STACK_empty, STACK_full,
           STACK_overflow, STACK_underflow
  );

  modport slave (
    input  STACK_valid, STACK_ctrl, STACK_push_addr, STACK_push_flags, STACK_err_clr,
    output STACK_top_addr, STACK_top_flags, STACK_count, STACK_empty, STACK_full,
           STACK_overflow, STACK_underflow
  );

endinterface

// File: rtl/nrisc_return_stack_lifo_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the owner's count.
module nrisc_lifo_ram #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int WORD_W = 19
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_wr_idx,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic [PTR_W-1:0]  i_rd_idx,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/nrisc_return_stack.sv
// Return-address LIFO: decodes the CPU stack command, keeps a registered top-of-stack,
// an entry count and sticky overflow/underflow flags.
module nrisc_return_stack
  import nrisc_return_stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int FLAG_W = STACK_FLAG_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int PTR_W  = STACK_PTR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  nrisc_return_stack_if.slave  i_stk
);

  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = DATA_W + FLAG_W;

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_top_addr;
  logic [FLAG_W-1:0] r_top_flags;
  logic              r_overflow;
  logic              r_underflow;

  stack_op_e         w_op;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_top_addr_nxt;
  logic [FLAG_W-1:0] w_top_flags_nxt;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_we;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_rd_idx;
  logic [WORD_W-1:0] w_rd_data;

  assign w_empty  = (r_count == CNT_W'(0));
  assign w_full   = (r_count == CNT_W'(DEPTH));
  // Pop lookahead: entry below the current top, i.e. index count-2.
  assign w_rd_idx = r_count[PTR_W-1:0] - PTR_W'(2);

  // Command decode and next-state computation
  always_comb begin
    w_op            = i_stk.STACK_valid ? stack_op_e'(i_stk.STACK_ctrl) : STACK_OP_IDLE;
    w_count_nxt     = r_count;
    w_top_addr_nxt  = r_top_addr;
    w_top_flags_nxt = r_top_flags;
    w_ovf_set       = 1'b0;
    w_unf_set       = 1'b0;
    w_we            = 1'b0;
    w_wr_idx        = r_count[PTR_W-1:0];
    case (w_op)
      STACK_OP_PUSH: begin
        if (!w_full) begin
          w_we            = 1'b1;
          w_count_nxt     = r_count + CNT_W'(1);
          w_top_addr_nxt  = i_stk.STACK_push_addr;
          w_top_flags_nxt = i_stk.STACK_push_flags;
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      STACK_OP_REPL: begin
        // An empty stack cannot be full, so replace-on-empty is an unconditional push.
        if (w_empty) begin
          w_we            = 1'b1;
          w_count_nxt     = r_count + CNT_W'(1);
          w_top_addr_nxt  = i_stk.STACK_push_addr;
          w_top_flags_nxt = i_stk.STACK_push_flags;
        end else begin
          w_we            = 1'b1;
          w_wr_idx        = r_count[PTR_W-1:0] - PTR_W'(1);
          w_top_addr_nxt  = i_stk.STACK_push_addr;
          w_top_flags_nxt = i_stk.STACK_push_flags;
        end
      end
      STACK_OP_POP: begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else if (r_count == CNT_W'(1)) begin
          w_count_nxt     = CNT_W'(0);
          w_top_addr_nxt  = DATA_W'(0);
          w_top_flags_nxt = FLAG_W'(0);
        end else begin
          w_count_nxt     = r_count - CNT_W'(1);
          w_top_addr_nxt  = w_rd_data[WORD_W-1:FLAG_W];
          w_top_flags_nxt = w_rd_data[FLAG_W-1:0];
        end
      end
      STACK_OP_IDLE: begin
        w_count_nxt = r_count;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  // State registers; a new error wins over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= CNT_W'(0);
      r_top_addr  <= DATA_W'(0);
      r_top_flags <= FLAG_W'(0);
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_top_addr  <= w_top_addr_nxt;
      r_top_flags <= w_top_flags_nxt;
      r_overflow  <= (r_overflow  & ~i_stk.STACK_err_clr) | w_ovf_set;
      r_underflow <= (r_underflow & ~i_stk.STACK_err_clr) | w_unf_set;
    end
  end

  nrisc_lifo_ram #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_we      (w_we & i_rst_n),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data ({i_stk.STACK_push_addr, i_stk.STACK_push_flags}),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  assign i_stk.STACK_top_addr  = r_top_addr;
  assign i_stk.STACK_top_flags = r_top_flags;
  assign i_stk.STACK_count     = r_count;
  assign i_stk.STACK_empty     = w_empty;
  assign i_stk.STACK_full      = w_full;
  assign i_stk.STACK_overflow  = r_overflow;
  assign i_stk.STACK_underflow = r_underflow;

endmodule
